// File: rtl/ssbr_pkg.sv
// ---------------------------------------------------------------------------
// ssbr_pkg
// Shared definitions for the parametrised serial/parallel shift register.
//   ssbr_mode_e : per-cycle operation select driven by the upstream controller
//                 HOLD=00, SHR=01 (stage i -> i+1), SHL=10 (stage i+1 -> i),
//                 LOAD=11 (parallel load)
// ---------------------------------------------------------------------------
package ssbr_pkg;

  typedef enum logic [1:0] {
    SSBR_HOLD = 2'b00,
    SSBR_SHR  = 2'b01,
    SSBR_SHL  = 2'b10,
    SSBR_LOAD = 2'b11
  } ssbr_mode_e;

endpackage

// File: rtl/ssbr_param_if.sv
// ---------------------------------------------------------------------------
// ssbr_param_if
// Control/data bundle of ssbr_param.
//   master : controller side, drives mode/clr/serial and parallel inputs,
//            observes end outputs, parallel outputs and occupancy flags
//   slave  : shift register side
// Parameters WIDTH/DEPTH must match the ssbr_param instance.
// ---------------------------------------------------------------------------
interface ssbr_param_if
  import ssbr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH + 1);

  ssbr_mode_e               mode;
  logic                     clr;
  logic [WIDTH-1:0]         sin_l;
  logic                     sin_l_vld;
  logic [WIDTH-1:0]         sin_r;
  logic                     sin_r_vld;
  logic [DEPTH*WIDTH-1:0]   pin;
  logic [DEPTH-1:0]         pin_vld;
  logic [WIDTH-1:0]         sout_l;
  logic                     sout_l_vld;
  logic [WIDTH-1:0]         sout_r;
  logic                     sout_r_vld;
  logic [DEPTH*WIDTH-1:0]   pout;
  logic [CW-1:0]            count;
  logic                     empty;
  logic                     full;

  modport master (
    output mode, clr, sin_l, sin_l_vld, sin_r, sin_r_vld, pin, pin_vld,
    input  sout_l, sout_l_vld, sout_r, sout_r_vld, pout, count, empty, full
  );

  modport slave (
    input  mode, clr, sin_l, sin_l_vld, sin_r, sin_r_vld, pin, pin_vld,
    output sout_l, sout_l_vld, sout_r, sout_r_vld, pout, count, empty, full
  );

endinterface

// File: rtl/ssbr_stage.sv
// ---------------------------------------------------------------------------
// ssbr_stage
// One storage stage: {vld, data} held in a WIDTH+1-bit register.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear, overrides mode
//   mode       : HOLD / SHR (take from_left) / SHL (take from_right) / LOAD
//   from_left  : {vld,data} of stage i-1 (or left serial input for stage 0)
//   from_right : {vld,data} of stage i+1 (or right serial input for last stage)
//   load_val   : {vld,data} parallel load value
//   q          : registered {vld,data}
// ---------------------------------------------------------------------------
module ssbr_stage
  import ssbr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  ssbr_mode_e mode,
  input  logic [WIDTH:0] from_left,
  input  logic [WIDTH:0] from_right,
  input  logic [WIDTH:0] load_val,
  output logic [WIDTH:0] q
);

  logic [WIDTH:0] q_reg;
  logic [WIDTH:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = '0;
    end else begin
      case (mode)
        SSBR_SHR:  q_next = from_left;
        SSBR_SHL:  q_next = from_right;
        SSBR_LOAD: q_next = load_val;
        default:   q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ssbr_param.sv
// ---------------------------------------------------------------------------
// ssbr_param
// Parametrised bidirectional serial/parallel shift register with a valid bit
// per stage and a registered occupancy count.
//   clk : clock, all state updates on rising edge
//   rst : asynchronous active-high reset
//   bus : ssbr_param_if.slave (mode/clr, serial ends, parallel in/out,
//         count/empty/full)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ssbr_param
  import ssbr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  ssbr_param_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH:0]         stage_q [DEPTH];
  logic [DEPTH-1:0]       vld;
  logic [DEPTH*WIDTH-1:0] pout_w;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH:0] from_left;
      logic [WIDTH:0] from_right;

      if (gi == 0) begin : g_left_end
        assign from_left = {bus.sin_l_vld, bus.sin_l};
      end else begin : g_left_mid
        assign from_left = stage_q[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_right_end
        assign from_right = {bus.sin_r_vld, bus.sin_r};
      end else begin : g_right_mid
        assign from_right = stage_q[gi+1];
      end

      ssbr_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.clr),
        .mode       (bus.mode),
        .from_left  (from_left),
        .from_right (from_right),
        .load_val   ({bus.pin_vld[gi], bus.pin[gi*WIDTH +: WIDTH]}),
        .q          (stage_q[gi])
      );

      assign vld[gi]                    = stage_q[gi][WIDTH];
      assign pout_w[gi*WIDTH +: WIDTH]  = stage_q[gi][WIDTH-1:0];
    end
  endgenerate

  // Occupancy tracking. Shifts adjust the count by the entering and exiting
  // valid bits only; the popcount is needed solely for parallel load.
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          empty_reg;
  logic          empty_next;
  logic          full_reg;
  logic          full_next;
  logic [CW-1:0] load_cnt;
  logic          in_bit;
  logic          out_bit;

  always_comb begin
    load_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load_cnt = load_cnt + CW'(bus.pin_vld[i]);
    end
  end

  always_comb begin
    in_bit     = 1'b0;
    out_bit    = 1'b0;
    count_next = count_reg;
    if (bus.clr) begin
      count_next = '0;
    end else begin
      case (bus.mode)
        SSBR_SHR: begin
          in_bit     = bus.sin_l_vld;
          out_bit    = vld[DEPTH-1];
          count_next = count_reg + CW'(in_bit) - CW'(out_bit);
        end
        SSBR_SHL: begin
          in_bit     = bus.sin_r_vld;
          out_bit    = vld[0];
          count_next = count_reg + CW'(in_bit) - CW'(out_bit);
        end
        SSBR_LOAD: count_next = load_cnt;
        default:   count_next = count_reg;
      endcase
    end
    // Flags are registered alongside the count so they describe the same edge.
    empty_next = (count_next == '0);
    full_next  = (count_next == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      empty_reg <= empty_next;
      full_reg  <= full_next;
    end
  end

  assign bus.sout_l     = stage_q[0][WIDTH-1:0];
  assign bus.sout_l_vld = vld[0];
  assign bus.sout_r     = stage_q[DEPTH-1][WIDTH-1:0];
  assign bus.sout_r_vld = vld[DEPTH-1];
  assign bus.pout       = pout_w;
  assign bus.count      = count_reg;
  assign bus.empty      = empty_reg;
  assign bus.full       = full_reg;

endmodule

// File: tb/tb_ssbr_param.sv
// ---------------------------------------------------------------------------
// tb_ssbr_param
// Directed vector table plus hand-written sequences for ssbr_param
// (WIDTH=8, DEPTH=4).
// ---------------------------------------------------------------------------
module tb_ssbr_param;
  import ssbr_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic clk;
  logic rst;

  ssbr_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  ssbr_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    ssbr_mode_e mode;
    logic       clr;
    logic [7:0] sin_l;
    logic       sin_l_vld;
    logic [7:0] sin_r;
    logic       sin_r_vld;
    logic [31:0] pin;
    logic [3:0] pin_vld;
    logic [31:0] e_pout;
    logic [7:0] e_sl;
    logic       e_slv;
    logic [7:0] e_sr;
    logic       e_srv;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input ssbr_mode_e m, input logic c,
                     input logic [7:0] sl, input logic slv,
                     input logic [7:0] sr, input logic srv,
                     input logic [31:0] p, input logic [3:0] pv,
                     input logic [31:0] ep, input logic [7:0] esl, input logic eslv,
                     input logic [7:0] esr, input logic esrv, input logic [2:0] ec);
    vec_t v;
    v.mode = m; v.clr = c; v.sin_l = sl; v.sin_l_vld = slv;
    v.sin_r = sr; v.sin_r_vld = srv; v.pin = p; v.pin_vld = pv;
    v.e_pout = ep; v.e_sl = esl; v.e_slv = eslv; v.e_sr = esr; v.e_srv = esrv;
    v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] ep, input logic [2:0] ec);
    chk({tag, ".pout"},  bus.pout, ep);
    chk({tag, ".count"}, 32'(bus.count), 32'(ec));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(ec == 3'd0));
    chk({tag, ".full"},  32'(bus.full),  32'(ec == 3'd4));
  endtask

  task automatic drive(input ssbr_mode_e m, input logic c,
                       input logic [7:0] sl, input logic slv,
                       input logic [7:0] sr, input logic srv,
                       input logic [31:0] p, input logic [3:0] pv);
    bus.mode = m; bus.clr = c;
    bus.sin_l = sl; bus.sin_l_vld = slv;
    bus.sin_r = sr; bus.sin_r_vld = srv;
    bus.pin = p; bus.pin_vld = pv;
  endtask

  logic [7:0] mdl_d [4];
  logic       mdl_v [4];
  int         pc;
  logic [31:0] mdl_pout;

  initial begin
    rst = 1'b1;
    drive(SSBR_HOLD, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);

    // --- Vector table ---
    //   mode       clr  sin_l  v    sin_r  v    pin           pv       pout          sl     v    sr     v    cnt
    add(SSBR_SHR,  0, 8'h01, 1, 8'h00, 0, 32'h0,        4'h0,    32'h00000001, 8'h01, 1, 8'h00, 0, 3'd1);
    add(SSBR_SHR,  0, 8'h02, 1, 8'h00, 0, 32'h0,        4'h0,    32'h00000102, 8'h02, 1, 8'h00, 0, 3'd2);
    add(SSBR_SHR,  0, 8'h03, 1, 8'h00, 0, 32'h0,        4'h0,    32'h00010203, 8'h03, 1, 8'h00, 0, 3'd3);
    add(SSBR_SHR,  0, 8'h04, 1, 8'h00, 0, 32'h0,        4'h0,    32'h01020304, 8'h04, 1, 8'h01, 1, 3'd4);
    // SHL drain with invalid words entering on the right
    add(SSBR_SHL,  0, 8'h00, 0, 8'h00, 0, 32'h0,        4'h0,    32'h00010203, 8'h03, 1, 8'h00, 0, 3'd3);
    add(SSBR_SHL,  0, 8'h00, 0, 8'h00, 0, 32'h0,        4'h0,    32'h00000102, 8'h02, 1, 8'h00, 0, 3'd2);
    add(SSBR_SHL,  0, 8'h00, 0, 8'h00, 0, 32'h0,        4'h0,    32'h00000001, 8'h01, 1, 8'h00, 0, 3'd1);
    add(SSBR_SHL,  0, 8'h00, 0, 8'h00, 0, 32'h0,        4'h0,    32'h00000000, 8'h00, 0, 8'h00, 0, 3'd0);
    // Parallel load, then hold
    add(SSBR_LOAD, 0, 8'h00, 0, 8'h00, 0, 32'h44332211, 4'b0101, 32'h44332211, 8'h11, 1, 8'h44, 0, 3'd2);
    add(SSBR_HOLD, 0, 8'h99, 1, 8'h99, 1, 32'hFFFFFFFF, 4'hF,    32'h44332211, 8'h11, 1, 8'h44, 0, 3'd2);
    // Valid in, invalid bubble out; then invalid in, valid out
    add(SSBR_SHR,  0, 8'h55, 1, 8'h00, 0, 32'h0,        4'h0,    32'h33221155, 8'h55, 1, 8'h33, 1, 3'd3);
    add(SSBR_SHL,  0, 8'h00, 0, 8'h66, 0, 32'h0,        4'h0,    32'h66332211, 8'h11, 1, 8'h66, 0, 3'd2);
    // clr overrides LOAD
    add(SSBR_LOAD, 1, 8'h00, 0, 8'h00, 0, 32'h12345678, 4'hF,    32'h00000000, 8'h00, 0, 8'h00, 0, 3'd0);
    // Full, then shift while full (word discarded), then invalid in valid out
    add(SSBR_LOAD, 0, 8'h00, 0, 8'h00, 0, 32'hAABBCCDD, 4'hF,    32'hAABBCCDD, 8'hDD, 1, 8'hAA, 1, 3'd4);
    add(SSBR_SHR,  0, 8'h05, 1, 8'h00, 0, 32'h0,        4'h0,    32'hBBCCDD05, 8'h05, 1, 8'hBB, 1, 3'd4);
    add(SSBR_SHR,  0, 8'h06, 0, 8'h00, 0, 32'h0,        4'h0,    32'hCCDD0506, 8'h06, 0, 8'hCC, 1, 3'd3);
    add(SSBR_HOLD, 1, 8'h00, 0, 8'h00, 0, 32'h0,        4'h0,    32'h00000000, 8'h00, 0, 8'h00, 0, 3'd0);
    // Invalid bubbles into empty register: data moves, count stays 0
    add(SSBR_SHR,  0, 8'h77, 0, 8'h00, 0, 32'h0,        4'h0,    32'h00000077, 8'h77, 0, 8'h00, 0, 3'd0);
    add(SSBR_SHR,  0, 8'h88, 0, 8'h00, 0, 32'h0,        4'h0,    32'h00007788, 8'h88, 0, 8'h00, 0, 3'd0);
    // Invalid in with invalid out on empty: count stays 0
    add(SSBR_SHL,  0, 8'h00, 0, 8'h99, 0, 32'h0,        4'h0,    32'h99000077, 8'h77, 0, 8'h99, 0, 3'd0);

    // --- Reset state ---
    #12;
    chk_state("reset", 32'h0, 3'd0);
    chk("reset.sout_l_vld", 32'(bus.sout_l_vld), 32'd0);
    rst = 1'b0;

    // --- Apply table ---
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mode, vecs[i].clr, vecs[i].sin_l, vecs[i].sin_l_vld,
            vecs[i].sin_r, vecs[i].sin_r_vld, vecs[i].pin, vecs[i].pin_vld);
      @(posedge clk); #1;
      $display("vec %0d mode=%0d clr=%0d pout=%h count=%0d empty=%0d full=%0d",
               i, vecs[i].mode, vecs[i].clr, bus.pout, bus.count, bus.empty, bus.full);
      chk_state($sformatf("vec%0d", i), vecs[i].e_pout, vecs[i].e_cnt);
      chk($sformatf("vec%0d.sout_l", i),     32'(bus.sout_l),     32'(vecs[i].e_sl));
      chk($sformatf("vec%0d.sout_l_vld", i), 32'(bus.sout_l_vld), 32'(vecs[i].e_slv));
      chk($sformatf("vec%0d.sout_r", i),     32'(bus.sout_r),     32'(vecs[i].e_sr));
      chk($sformatf("vec%0d.sout_r_vld", i), 32'(bus.sout_r_vld), 32'(vecs[i].e_srv));
    end

    // --- Alternating SHR/SHL with random valids against a shifting model ---
    drive(SSBR_HOLD, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      mdl_d[i] = 8'h00;
      mdl_v[i] = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      drive((k % 2 == 0) ? SSBR_SHR : SSBR_SHL, 1'b0,
            8'($urandom), 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 1)), 32'h0, 4'h0);
      if (k % 2 == 0) begin
        for (int i = 3; i > 0; i--) begin
          mdl_d[i] = mdl_d[i-1];
          mdl_v[i] = mdl_v[i-1];
        end
        mdl_d[0] = bus.sin_l;
        mdl_v[0] = bus.sin_l_vld;
      end else begin
        for (int i = 0; i < 3; i++) begin
          mdl_d[i] = mdl_d[i+1];
          mdl_v[i] = mdl_v[i+1];
        end
        mdl_d[3] = bus.sin_r;
        mdl_v[3] = bus.sin_r_vld;
      end
      pc = 0;
      for (int i = 0; i < 4; i++) begin
        pc += int'(mdl_v[i]);
        mdl_pout[i*8 +: 8] = mdl_d[i];
      end
      @(posedge clk); #1;
      $display("alt %0d mode=%0d pout=%h count=%0d model_count=%0d",
               k, bus.mode, bus.pout, bus.count, pc);
      chk_state($sformatf("alt%0d", k), mdl_pout, 3'(pc));
      chk($sformatf("alt%0d.sout_l_vld", k), 32'(bus.sout_l_vld), 32'(mdl_v[0]));
      chk($sformatf("alt%0d.sout_r_vld", k), 32'(bus.sout_r_vld), 32'(mdl_v[3]));
    end

    // --- Asynchronous reset mid-operation ---
    drive(SSBR_HOLD, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    drive(SSBR_SHR, 1'b0, 8'hAA, 1'b1, 8'h00, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("pre_rst pout=%h count=%0d", bus.pout, bus.count);
    chk_state("pre_rst", 32'h0000AAAA, 3'd2);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    $display("async_rst pout=%h count=%0d", bus.pout, bus.count);
    chk_state("async_rst", 32'h0, 3'd0);
    chk("async_rst.sout_l_vld", 32'(bus.sout_l_vld), 32'd0);
    @(posedge clk); #1;
    chk_state("rst_held", 32'h0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    $display("post_rst pout=%h count=%0d", bus.pout, bus.count);
    chk_state("post_rst", 32'h000000AA, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssbr_param.md
# ssbr_param

Parametrised serial/parallel bidirectional shift register, successor to the fixed 4-bit SSBR, with WIDTH-bit lanes and DEPTH stages. Adds parallel load, hold, synchronous clear, a valid bit per stage and a registered occupancy count with full/empty flags. It is the storage primitive for the next-generation FIFO and serial-link blocks, where an upstream controller drives the mode each cycle and consumes data at either end.

## Interface
Parameters:
- WIDTH, 8, bits per stage (≥1)
- DEPTH, 4, number of stages (≥2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  2  operation select: HOLD=00, SHR=01 (stage i → i+1), SHL=10 (stage i+1 → i), LOAD=11
- clr  input  1  synchronous clear; overrides mode
- sin_l  input  WIDTH  serial data entering stage 0 on SHR
- sin_l_vld  input  1  valid bit accompanying sin_l
- sin_r  input  WIDTH  serial data entering stage DEPTH-1 on SHL
- sin_r_vld  input  1  valid bit accompanying sin_r
- pin  input  DEPTH*WIDTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
- pin_vld  input  DEPTH  per-stage valid bits for LOAD
- sout_l  output  WIDTH  stage 0 data (QL)
- sout_l_vld  output  1  stage 0 valid
- sout_r  output  WIDTH  stage DEPTH-1 data (QR)
- sout_r_vld  output  1  stage DEPTH-1 valid
- pout  output  DEPTH*WIDTH  all stage data, same packing as pin
- count  output  $clog2(DEPTH+1)  number of valid stages
- empty  output  1  count == 0
- full  output  1  count == DEPTH

## Operation
- State: data[DEPTH][WIDTH], vld[DEPTH], count.
- Priority per edge: rst (async) > clr > mode.
- rst/clr: all data, vld and count go to 0; empty=1, full=0.
- HOLD: no change.
- SHR: data/vld[0] ← sin_l/sin_l_vld; stage i+1 ← stage i. Stage DEPTH-1 contents leave via the right end; pre-edge sout_r is the word shifted out.
- SHL: data/vld[DEPTH-1] ← sin_r/sin_r_vld; stage i ← stage i+1. Stage 0 contents leave via the left end.
- LOAD: data ← pin, vld ← pin_vld; count ← popcount(pin_vld).
- Count update on shift: count_next = count + in_vld − out_vld, where in_vld is the entering valid bit and out_vld is the valid bit of the exiting stage. Computed incrementally, with no popcount in the shift path. Invariant: count == popcount(vld) at all times.
- Shifting in while full with the exit stage valid keeps count at DEPTH (the word is discarded off the end). With the exit stage invalid, an invalid bubble is dropped.
- Shifting an invalid word in with a valid word out decrements count; on empty, count stays 0.
- Data bits of invalid stages are still shifted and visible on pout; consumers qualify them with the vld outputs.
- Changing mode every cycle (SHR→SHL→…) is legal; each edge is evaluated independently.

## Timing
- All outputs come directly from registers: sout_*, pout, count, empty and full have no combinational path from inputs.
- Latency: a serial input appears at the adjacent end output after 1 edge and at the far end after DEPTH edges. Parallel load is visible after 1 edge.
- count, empty and full are updated on the same edge as the data they describe.
- rst asserted mid-operation clears everything immediately (asynchronously). The first state update after deassertion happens on the next rising edge at which rst is low.

## Structure
- Shared package ssbr_pkg holds the mode encodings: SSBR_HOLD, SSBR_SHR, SSBR_SHL, SSBR_LOAD.
- One sub-module, ssbr_stage: a WIDTH+1-bit register with a 4:1 next-state mux (hold/left neighbour/right neighbour/load) plus clr. It is instantiated DEPTH times by generate; end stages connect to sin_l/sin_r.
- The count/flag logic lives in the top module.

## Test plan
- Reset: drive mode=SHR, sin_l=8'hAA, sin_l_vld=1, then assert rst asynchronously between edges → pout=0, count=0, empty=1, full=0 immediately, without waiting for an edge.
- SHR fill (DEPTH=4, WIDTH=8): shift in 01,02,03,04 with vld=1 → after 4 edges sout_r=01, sout_l=04, count=4, full=1. A fifth SHR of 05 with vld=1 → sout_r=02, count stays 4.
- SHL drain: from the full state, 4× SHL with sin_r_vld=0 → sout_l sequence 03,02,01,00 with valid falling off; count 4→3→2→1→0; empty=1 after the 4th edge.
- LOAD: pin=32'h44332211, pin_vld=4'b0101 → pout=44332211, count=2, sout_l_vld=1, sout_r_vld=0. Next a HOLD → nothing changes.
- clr vs mode: mode=LOAD with clr=1 on the same edge → all zero, count=0. Alternating SHR/SHL for 8 cycles with random valids → count always equals popcount of the valid bits.
- Invalid bubbles: SHR of invalid words into an empty register → count stays 0 and empty stays 1, while data still moves on pout.
